condicionador_botoes: RTL and testbench
=======================================

# condicionador_botoes

Front-end conditioner for the seven note buttons. It synchronises and debounces the raw switch inputs and reduces them to a clean vector that is either all zeros or exactly one-hot. That vector drives the datapath's `botoes` input, where the any-button OR and edge detector turn each press into one `jogadafeita` pulse. Multiple simultaneous presses and presses already held when `enable` rises are blocked until every button is released, so neither can register as a play.

## Interface
- `N_BOTOES`, 7: number of buttons; fixes the width of `botoes_raw` and `botoes`.
- `DEBOUNCE_CYCLES`, 20: consecutive stable synchronised samples required to accept a level change (20 ms at the 1 kHz system clock). Legal range 1..2^`CW`-1.
- `CW`, 8: width of each debounce counter.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `botoes_raw`  in  `N_BOTOES`  raw button levels, active-high, asynchronous to `clock`, may bounce.
- `enable`  in  1  from the control FSM; high while plays are accepted.
- `botoes`  out  `N_BOTOES`  conditioned vector; 0 or exactly one bit set.
- `pressionado`  out  1  high exactly when `botoes` != 0.
- `multiplo`  out  1  one-cycle pulse when a multiple press is rejected.
- `db_estado`  out  2  FSM state for debug: 00 OCIOSO, 01 PRESSIONADO, 10 BLOQUEADO.

## Operation
**Synchroniser**
- Each `botoes_raw` bit passes through a 2-flop synchroniser, giving `s`.

**Debouncer (per bit)**
- Holds a debounced level `d` and a counter `c`.
- If `s` != `d`: `c` increments. When `c` == `DEBOUNCE_CYCLES`-1 and `s` still differs, `d` toggles and `c` clears.
- If `s` == `d`: `c` clears immediately. Any bounce shorter than `DEBOUNCE_CYCLES` samples is therefore discarded.

**FSM**
- Inputs are the debounced vector `d` and `enable`.
- `one_hot` = `d` has exactly one bit set; `multi` = `d` has two or more bits set.
- The held code `cod` is registered.

**OCIOSO**
- `botoes` = 0.
- `enable` & `one_hot` → PRESSIONADO; `cod` <= `d`.
- `enable` & `multi` → BLOQUEADO; pulse `multiplo`.
- !`enable` & `d` != 0 → BLOQUEADO; no `multiplo` pulse.

**PRESSIONADO**
- `botoes` = `cod`.
- `d` == 0 → OCIOSO.
- `d` has any bit set outside `cod` → BLOQUEADO; pulse `multiplo`.
- !`enable` → BLOQUEADO.
- Otherwise (`d` == `cod`) → stay.

**BLOQUEADO**
- `botoes` = 0.
- Leave only when `d` == 0, going to OCIOSO; `enable` is ignored.

**Outputs and simultaneous events**
- `botoes`, `pressionado`, `multiplo` and `db_estado` are registered (Moore outputs).
- A release and a new press of a different button in the same cycle pass through OCIOSO first. `botoes` therefore always returns to 0 for at least 1 cycle between two plays, which guarantees a rising edge for the downstream edge detector.
- In PRESSIONADO, if the extra-bit and `enable`-low conditions coincide, the extra-bit condition takes priority and `multiplo` pulses.

## Timing
- Reset values: `botoes`=0, `pressionado`=0, `multiplo`=0, `db_estado`=00. All synchroniser flops, `d`, `c` and `cod` are 0.
- Reset asserted mid-press returns to OCIOSO.
- If a button is still held at reset release with `enable`=1, it is accepted as a fresh press after the full debounce latency.
- Press latency: `botoes_raw` stable before edge k → `d` set at edge k+1+`DEBOUNCE_CYCLES` → `botoes` set at edge k+2+`DEBOUNCE_CYCLES`.
- Release latency is the same.
- `multiplo` is high for exactly 1 cycle, aligned with the edge on which `db_estado` becomes 10.
- `enable` has 1-cycle effect latency: it is sampled on the same edge as the FSM transition.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset values:** assert `reset` mid-operation → `botoes`=0, `pressionado`=0 and `db_estado`=00 immediately, asynchronously.
- **Clean press:** `enable`=1; `botoes_raw`=0000100 held from before edge 0 → `botoes`=0000100 and `pressionado`=1 from edge 6. Release before edge 20 → `botoes`=0 from edge 26.
- **Bounce rejection:** 3-cycle high glitches on bit 1, separated by 1-cycle lows → `botoes` stays 0 and `db_estado` stays 00.
- **Multiple press:** hold bit 0; 10 cycles later add bit 5 → `botoes` drops to 0 and `multiplo` pulses once, with `db_estado`=10. Release bit 0 only → still 0. Release bit 5 → `db_estado`=00 six edges later.
- **Held before enable:** bit 3 held with `enable`=0, then `enable`=1 → `botoes` stays 0 and `multiplo` stays 0 until release. A later press of bit 3 → `botoes`=0001000.
- **Enable drop:** `enable` falls during PRESSIONADO → `botoes`=0 on the next edge and `db_estado`=10. No new play until all buttons are released.

Source files
------------

// File: rtl/condicionador_botoes.sv
// Front-end conditioner for the note buttons: 2-flop synchroniser, per-bit debouncer
// and a small FSM that only lets a clean one-hot press through to the datapath.
module condicionador_botoes #(
  parameter int N_BOTOES        = 7,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CW              = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                enable,
  output logic [N_BOTOES-1:0] botoes,
  output logic                pressionado,
  output logic                multiplo,
  output logic [1:0]          db_estado
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'b00,
    PRESSIONADO = 2'b01,
    BLOQUEADO   = 2'b10
  } estado_t;

  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] r_sync1;
  logic [N_BOTOES-1:0] r_sync2;
  logic [N_BOTOES-1:0] r_deb;
  logic [CW-1:0]       r_cnt [N_BOTOES];
  logic [N_BOTOES-1:0] r_cod;
  logic [N_BOTOES-1:0] r_botoes;
  logic                r_pressionado;
  logic                r_multiplo;
  estado_t             r_estado;

  logic [N_BOTOES-1:0] w_debMenos1;
  logic                w_algum;
  logic                w_multi;
  logic                w_oneHot;
  logic                w_foraCod;
  logic                w_soltouCod;
  estado_t             w_proxEstado;
  logic [N_BOTOES-1:0] w_proxCod;
  logic                w_pulsoMultiplo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= botoes_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < N_BOTOES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BOTOES; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == LIMITE) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign w_debMenos1 = r_deb - N_BOTOES'(1);
  assign w_algum     = |r_deb;
  assign w_multi     = |(r_deb & w_debMenos1);
  assign w_oneHot    = w_algum & ~w_multi;
  assign w_foraCod   = |(r_deb & ~r_cod);
  assign w_soltouCod = ~|(r_deb & r_cod);

  // Losing the held bit wins over everything so a release-and-swap passes through OCIOSO.
  always_comb begin
    w_proxEstado    = r_estado;
    w_proxCod       = r_cod;
    w_pulsoMultiplo = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (enable && w_oneHot) begin
          w_proxEstado = PRESSIONADO;
          w_proxCod    = r_deb;
        end else if (enable && w_multi) begin
          w_proxEstado    = BLOQUEADO;
          w_pulsoMultiplo = 1'b1;
        end else if (!enable && w_algum) begin
          w_proxEstado = BLOQUEADO;
        end
      end
      PRESSIONADO: begin
        if (w_soltouCod) begin
          w_proxEstado = OCIOSO;
        end else if (w_foraCod) begin
          w_proxEstado    = BLOQUEADO;
          w_pulsoMultiplo = 1'b1;
        end else if (!enable) begin
          w_proxEstado = BLOQUEADO;
        end
      end
      BLOQUEADO: begin
        if (!w_algum) begin
          w_proxEstado = OCIOSO;
        end
      end
      default: begin
        w_proxEstado = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado      <= OCIOSO;
      r_cod         <= '0;
      r_botoes      <= '0;
      r_pressionado <= 1'b0;
      r_multiplo    <= 1'b0;
    end else begin
      r_estado      <= w_proxEstado;
      r_cod         <= w_proxCod;
      r_botoes      <= (w_proxEstado == PRESSIONADO) ? w_proxCod : '0;
      r_pressionado <= (w_proxEstado == PRESSIONADO);
      r_multiplo    <= w_pulsoMultiplo;
    end
  end

  assign botoes      = r_botoes;
  assign pressionado = r_pressionado;
  assign multiplo    = r_multiplo;
  assign db_estado   = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes: a history-based reference model predicts
// every output change with its cycle stamp; a monitor pops and compares on each change.
module tb_condicionador_botoes;

  localparam int N      = 7;
  localparam int DEB    = 4;
  localparam int IDLE_M = 0;
  localparam int HELD_M = 1;
  localparam int BLK_M  = 2;

  typedef struct {
    int          cyc;
    logic [10:0] val;
  } evento_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] botoesRaw;
  logic [N-1:0] botoes;
  logic         pressionado;
  logic         multiplo;
  logic [1:0]   dbEstado;

  int      checks     = 0;
  int      errors     = 0;
  int      cycleCount = 0;
  evento_t sbQ[$];

  logic [N-1:0] mD, mCod, h1, h2, seenNow, mBot;
  logic [N-1:0] seenQ[$];
  int           mMode;
  logic         mMulti;
  logic         allDiff;
  logic [10:0]  expVal;
  logic [10:0]  lastExp = '0;
  logic [10:0]  obs;
  logic [10:0]  lastObs = '0;
  evento_t      ev;

  logic [N-1:0] randPat;
  logic         randEn;
  int           kind;
  int           holdLen;

  condicionador_botoes #(
    .N_BOTOES(N),
    .DEBOUNCE_CYCLES(DEB),
    .CW(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .botoes_raw(botoesRaw),
    .enable(enable),
    .botoes(botoes),
    .pressionado(pressionado),
    .multiplo(multiplo),
    .db_estado(dbEstado)
  );

  always #5 clock = ~clock;

  // Reference model: a bit toggles once its last DEB synchronised samples all disagree with it.
  always @(posedge clock) begin
    cycleCount++;
    if (reset) begin
      mD     = '0;
      mCod   = '0;
      h1     = '0;
      h2     = '0;
      mMode  = IDLE_M;
      mMulti = 1'b0;
      seenQ.delete();
    end else begin
      seenNow = h2;
      h2      = h1;
      h1      = botoesRaw;
      mMulti  = 1'b0;
      case (mMode)
        IDLE_M: begin
          if (enable && $countones(mD) == 1) begin
            mMode = HELD_M;
            mCod  = mD;
          end else if (enable && $countones(mD) > 1) begin
            mMode  = BLK_M;
            mMulti = 1'b1;
          end else if (!enable && mD != 0) begin
            mMode = BLK_M;
          end
        end
        HELD_M: begin
          if ((mD & mCod) == 0) mMode = IDLE_M;
          else if ((mD & ~mCod) != 0) begin
            mMode  = BLK_M;
            mMulti = 1'b1;
          end else if (!enable) mMode = BLK_M;
        end
        default: if (mD == 0) mMode = IDLE_M;
      endcase
      seenQ.push_back(seenNow);
      if (seenQ.size() > DEB) void'(seenQ.pop_front());
      if (seenQ.size() == DEB) begin
        for (int b = 0; b < N; b++) begin
          allDiff = 1'b1;
          foreach (seenQ[i]) if (seenQ[i][b] == mD[b]) allDiff = 1'b0;
          if (allDiff) mD[b] = ~mD[b];
        end
      end
    end
    mBot   = (mMode == HELD_M) ? mCod : '0;
    expVal = {mBot, (mMode == HELD_M), mMulti, 2'(mMode)};
    if (expVal !== lastExp) begin
      sbQ.push_back('{cyc: cycleCount, val: expVal});
      lastExp = expVal;
    end
  end

  // Monitor: every change in the DUT outputs must match the next predicted event.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      obs = {botoes, pressionado, multiplo, dbEstado};
      if (obs !== lastObs) begin
        lastObs = obs;
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_change cycle %0d got %b expected no change", cycleCount, obs);
        end else begin
          ev = sbQ.pop_front();
          if (ev.cyc != cycleCount || ev.val !== obs) begin
            errors++;
            $display("[TB] FAIL output_event got %b at cycle %0d, expected %b at cycle %0d",
                     obs, cycleCount, ev.val, ev.cyc);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic applyStimulus(input logic [N-1:0] raw, input logic en, input int cycles);
    botoesRaw = raw;
    enable    = en;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    checkOutput("reset_botoes", 32'(botoes), 32'h0);
    checkOutput("reset_pressionado", 32'(pressionado), 32'h0);
    checkOutput("reset_estado", 32'(dbEstado), 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    botoesRaw = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    applyStimulus('0, 1'b1, 8);

    // Clean press: raw set before edge 0, expected out at edge 6, release before 20, clear at 26.
    botoesRaw = 7'b0000100;
    repeat (6) @(posedge clock);
    #1 checkOutput("press_edge5", 32'(botoes), 32'h0);
    @(posedge clock);
    #1 checkOutput("press_edge6", 32'(botoes), 32'h04);
    checkOutput("press_pressionado", 32'(pressionado), 32'h1);
    repeat (14) @(negedge clock);
    botoesRaw = '0;
    repeat (6) @(posedge clock);
    #1 checkOutput("release_edge25", 32'(botoes), 32'h04);
    @(posedge clock);
    #1 checkOutput("release_edge26", 32'(botoes), 32'h0);
    @(negedge clock);
    applyStimulus('0, 1'b1, 4);

    for (int g = 0; g < 4; g++) begin
      applyStimulus(7'b0000010, 1'b1, 3);
      applyStimulus(7'b0000000, 1'b1, 1);
    end
    applyStimulus('0, 1'b1, 10);
    checkOutput("bounce_estado", 32'(dbEstado), 32'h0);

    applyStimulus(7'b0000001, 1'b1, 10);
    applyStimulus(7'b0100001, 1'b1, 12);
    applyStimulus(7'b0100000, 1'b1, 12);
    checkOutput("multi_still_blocked", 32'(botoes), 32'h0);
    applyStimulus(7'b0000000, 1'b1, 12);

    applyStimulus(7'b0001000, 1'b0, 10);
    applyStimulus(7'b0001000, 1'b1, 10);
    checkOutput("held_before_enable", 32'(botoes), 32'h0);
    applyStimulus(7'b0000000, 1'b1, 10);
    applyStimulus(7'b0001000, 1'b1, 10);
    checkOutput("held_later_press", 32'(botoes), 32'h08);
    applyStimulus(7'b0000000, 1'b1, 10);

    applyStimulus(7'b0000100, 1'b1, 10);
    applyStimulus(7'b0000100, 1'b0, 5);
    applyStimulus(7'b0000100, 1'b1, 10);
    checkOutput("enable_drop_estado", 32'(dbEstado), 32'h2);
    applyStimulus(7'b0000000, 1'b1, 10);

    applyStimulus(7'b1000000, 1'b1, 10);
    applyReset();
    applyStimulus(7'b1000000, 1'b1, 10);
    applyStimulus(7'b0000000, 1'b1, 10);

    randPat = '0;
    randEn  = 1'b1;
    for (int step = 0; step < 300; step++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) randPat = '0;
      else if (kind < 8) randPat = N'(1) << $urandom_range(0, N - 1);
      else if (kind == 8) randPat = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
      else randPat = randPat ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 7) == 0) randEn = ~randEn;
      holdLen = $urandom_range(1, 10);
      if ($urandom_range(0, 59) == 0) applyReset();
      applyStimulus(randPat, randEn, holdLen);
    end

    applyStimulus('0, 1'b1, 20);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
